// File: rtl/rt_pkg.sv
// Shared types and defaults for the ray-tracing frame sequencer.
package rt_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef logic [3:0]  pixel_t;
  typedef logic [9:0]  xcoord_t;
  typedef logic [8:0]  ycoord_t;
  typedef logic [18:0] fbaddr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WRITE     = 3'd4,
    ST_DONE      = 3'd5
  } sched_state_t;

endpackage

// File: rtl/rt_raster_counter.sv
// Raster walker: owns X, Y and the linear framebuffer address. The address
// tracks Y*H_RES+X by incrementing alongside X, so no multiplier is needed.
module rt_raster_counter
  import rt_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_clear,
  input  logic    i_advance,
  output xcoord_t o_x,
  output ycoord_t o_y,
  output fbaddr_t o_addr,
  output logic    o_last
);

  xcoord_t r_x;
  ycoord_t r_y;
  fbaddr_t r_addr;
  logic    w_x_end;
  logic    w_last;

  assign w_x_end = (r_x == xcoord_t'(H_RES - 1));
  assign w_last  = w_x_end && (r_y == ycoord_t'(V_RES - 1));

  // Step the coordinate pair in raster order; the last pixel holds X/Y so
  // the frame's final coordinates stay visible until the next clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_advance) begin
      r_addr <= r_addr + 1'b1;
      if (!w_last) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_addr = r_addr;
  assign o_last = w_last;

endmodule

// File: rtl/rt_pixel_scheduler.sv
// Frame sequencer: issues one pixel at a time to RTcore, waits for its result
// (with a per-pixel watchdog), and writes it to the framebuffer.
//
// Handshakes:
//   core: CORE_ENABLE is a one-cycle request. The request counts as accepted
//         only once CORE_READY is seen low; the result is taken on the next
//         CORE_READY high. A READY that is already high at request time is
//         stale and never treated as a result.
//   fb:   a write transfers on every rising edge where FB_WE && FB_READY;
//         while FB_WE is high and FB_READY low, FB_ADDR/FB_DATA hold stable.
module rt_pixel_scheduler
  import rt_pkg::*;
#(
  parameter int unsigned H_RES     = H_RES_DEF,
  parameter int unsigned V_RES     = V_RES_DEF,
  parameter int unsigned TIMEOUT   = 4095,
  parameter pixel_t      ERR_PIXEL = 4'hC
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         CONTINUOUS,
  output logic         CORE_ENABLE,
  output logic [9:0]   CORE_X,
  output logic [8:0]   CORE_Y,
  input  logic         CORE_READY,
  input  logic [3:0]   CORE_PIXEL,
  output logic         FB_WE,
  output logic [18:0]  FB_ADDR,
  output logic [3:0]   FB_DATA,
  input  logic         FB_READY,
  output logic         BUSY,
  output logic         FRAME_DONE,
  output logic [15:0]  FRAME_COUNT,
  output logic         TIMEOUT_ERR,
  output sched_state_t DBG_STATE
);

  // Wide enough to hold TIMEOUT+1 without wrapping.
  localparam int unsigned WD_W = $clog2(TIMEOUT + 2);

  sched_state_t    r_state;
  logic            r_core_enable;
  logic            r_fb_we;
  pixel_t          r_fb_data;
  logic            r_busy;
  logic            r_frame_done;
  logic [15:0]     r_frame_count;
  logic            r_timeout_err;
  logic [WD_W-1:0] r_wd;

  logic [WD_W-1:0] w_wd_next;
  logic            w_wd_expired;
  logic            w_clear;
  logic            w_advance;
  logic            w_last;
  xcoord_t         w_x;
  ycoord_t         w_y;
  fbaddr_t         w_addr;

  assign w_wd_next    = r_wd + 1'b1;
  assign w_wd_expired = (32'(w_wd_next) >= TIMEOUT);
  assign w_clear      = ((r_state == ST_IDLE) && START) ||
                        ((r_state == ST_DONE) && CONTINUOUS);
  assign w_advance    = (r_state == ST_WRITE) && FB_READY;

  rt_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // Scheduler FSM with registered outputs; a result arriving on the same
  // edge the watchdog expires takes priority over the timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_core_enable <= 1'b0;
      r_fb_we       <= 1'b0;
      r_fb_data     <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_core_enable <= 1'b0;
      r_frame_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_state       <= ST_ISSUE;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_core_enable <= 1'b1;
          r_wd          <= '0;
          r_state       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!CORE_READY) begin
            r_wd    <= w_wd_next;
            r_state <= ST_WAIT_DONE;
          end else if (w_wd_expired) begin
            r_fb_data     <= ERR_PIXEL;
            r_timeout_err <= 1'b1;
            r_fb_we       <= 1'b1;
            r_state       <= ST_WRITE;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        ST_WAIT_DONE: begin
          if (CORE_READY) begin
            r_fb_data <= CORE_PIXEL;
            r_fb_we   <= 1'b1;
            r_state   <= ST_WRITE;
          end else if (w_wd_expired) begin
            r_fb_data     <= ERR_PIXEL;
            r_timeout_err <= 1'b1;
            r_fb_we       <= 1'b1;
            r_state       <= ST_WRITE;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        ST_WRITE: begin
          if (FB_READY) begin
            r_fb_we <= 1'b0;
            if (w_last) begin
              r_frame_done  <= 1'b1;
              r_frame_count <= r_frame_count + 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          if (CONTINUOUS) begin
            r_state <= ST_ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_fb_we <= 1'b0;
        end
      endcase
    end
  end

  assign CORE_ENABLE = r_core_enable;
  assign CORE_X      = w_x;
  assign CORE_Y      = w_y;
  assign FB_WE       = r_fb_we;
  assign FB_ADDR     = w_addr;
  assign FB_DATA     = r_fb_data;
  assign BUSY        = r_busy;
  assign FRAME_DONE  = r_frame_done;
  assign FRAME_COUNT = r_frame_count;
  assign TIMEOUT_ERR = r_timeout_err;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// Bench for rt_pixel_scheduler on a 4x3 screen with a 5-cycle core model.
module tb_rt_pixel_scheduler;
  import rt_pkg::*;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int NPX = H * V;
  localparam int TO  = 20;
  localparam int LAT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start      = 1'b0;
  logic         continuous = 1'b0;
  logic         core_ready = 1'b1;
  logic [3:0]   core_pixel = 4'h0;
  logic         fb_ready   = 1'b1;
  logic         core_enable;
  logic [9:0]   core_x;
  logic [8:0]   core_y;
  logic         fb_we;
  logic [18:0]  fb_addr;
  logic [3:0]   fb_data;
  logic         busy;
  logic         frame_done;
  logic [15:0]  frame_count;
  logic         timeout_err;
  sched_state_t dbg_state;

  rt_pixel_scheduler #(
    .H_RES     (H),
    .V_RES     (V),
    .TIMEOUT   (TO),
    .ERR_PIXEL (4'hC)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .START       (start),
    .CONTINUOUS  (continuous),
    .CORE_ENABLE (core_enable),
    .CORE_X      (core_x),
    .CORE_Y      (core_y),
    .CORE_READY  (core_ready),
    .CORE_PIXEL  (core_pixel),
    .FB_WE       (fb_we),
    .FB_ADDR     (fb_addr),
    .FB_DATA     (fb_data),
    .FB_READY    (fb_ready),
    .BUSY        (busy),
    .FRAME_DONE  (frame_done),
    .FRAME_COUNT (frame_count),
    .TIMEOUT_ERR (timeout_err),
    .DBG_STATE   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel value the core produces for a coordinate.
  function automatic logic [3:0] pix(input int x, input int y, input int s);
    int v;
    v = x * 5 + y * 3 + s;
    return v[3:0];
  endfunction

  // ---------------- core model ----------------
  int         salt = 0;
  logic       core_stuck = 1'b0;
  int         core_cnt = 0;
  int         core_xl = 0;
  int         core_yl = 0;
  always @(negedge clk) begin
    if (core_enable && !core_stuck) begin
      core_xl    = int'(core_x);
      core_yl    = int'(core_y);
      core_ready = 1'b0;
      core_cnt   = LAT;
    end else if (!core_ready) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_ready = 1'b1;
        core_pixel = pix(core_xl, core_yl, salt);
      end
    end
  end

  // ---------------- framebuffer backpressure driver ----------------
  int stall_addr = -1;
  int stall_left = 0;
  int stall_seen = 0;
  always @(negedge clk) begin
    if (fb_we && (32'(fb_addr) == stall_addr) && stall_left > 0) begin
      fb_ready = 1'b0;
      stall_left--;
      stall_seen++;
    end else begin
      fb_ready = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];   // {addr, data} of each write, in order
  logic        chk_en = 1'b0;
  int          n_en = 0;
  int          n_wr = 0;
  int          n_fd = 0;
  int          fc_model = 0;

  task automatic push_frame(input logic stuck);
    for (int k = 0; k < NPX; k++) begin
      logic [3:0] d;
      d = stuck ? 4'hC : pix(k % H, k / H, salt);
      exp_q.push_back({19'(k), d});
    end
  endtask

  logic        prev_en   = 1'b0;
  logic        prev_hold = 1'b0;
  logic        prev_last = 1'b0;
  logic [18:0] held_addr;
  logic [3:0]  held_data;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      fc_model  = 0;
      prev_hold = 1'b0;
      prev_last = 1'b0;
    end else if (chk_en) begin
      if (core_enable) begin
        n_en++;
        check("enable_single_cycle", 32'(prev_en), 32'd0);
        check("enable_has_pixel", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          int a;
          a = int'(exp_q[0][22:4]);
          check("core_xy", {13'd0, core_y, core_x}, {13'd0, 9'(a / H), 10'(a % H)});
        end
      end
      if (fb_we) check("no_enable_during_write", 32'(core_enable), 32'd0);
      if (prev_hold) begin
        check("hold_we", 32'(fb_we), 32'd1);
        check("hold_addr", 32'(fb_addr), 32'(held_addr));
        check("hold_data", 32'(fb_data), 32'(held_data));
      end
      if (prev_last || frame_done) check("frame_done_after_last", 32'(frame_done), 32'(prev_last));
      if (frame_done) begin
        n_fd++;
        fc_model = (fc_model + 1) % 65536;
        check("frame_count", 32'(frame_count), 32'(fc_model));
      end
      prev_last = 1'b0;
      if (fb_we && fb_ready) begin
        n_wr++;
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [22:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e[22:4]));
          check("wr_data", 32'(fb_data), 32'(e[3:0]));
        end
        prev_last = (32'(fb_addr) == NPX - 1);
      end
      prev_hold = fb_we && !fb_ready;
      held_addr = fb_addr;
      held_data = fb_data;
    end
    prev_en = core_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_frame_done(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < budget);
    check("frame_done_wait", 32'(frame_done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, 32'(core_enable), 32'd0);
    check({tag, "_we"}, 32'(fb_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fd"}, 32'(frame_done), 32'd0);
    check({tag, "_terr"}, 32'(timeout_err), 32'd0);
    check({tag, "_xy"}, {13'd0, core_y, core_x}, 32'd0);
    check({tag, "_addr"}, 32'(fb_addr), 32'd0);
    check({tag, "_data"}, 32'(fb_data), 32'd0);
    check({tag, "_fc"}, 32'(frame_count), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int en0, wr0, fd0, n;
    #1 rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // Frame 1: FB_READY always high; START->ENABLE takes 2 edges.
    salt = 3;
    push_frame(1'b0);
    chk_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_enable_edge1", 32'(core_enable), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    step();
    check("start_enable_edge2", 32'(core_enable), 32'd1);
    wait_frame_done(400);
    check("f1_count_literal", 32'(frame_count), 32'd1);
    step(); step();
    check("f1_idle_busy", 32'(busy), 32'd0);
    check("f1_writes", 32'(n_wr), 32'd12);
    check("f1_enables", 32'(n_en), 32'd12);
    check("f1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Frame 2: pixel 5 stalled for 7 cycles.
    salt = 6;
    push_frame(1'b0);
    stall_addr = 5;
    stall_left = 7;
    en0 = n_en;
    pulse_start();
    wait_frame_done(400);
    stall_addr = -1;
    step();
    check("stall_cycles", 32'(stall_seen), 32'd7);
    check("stall_enables", 32'(n_en - en0), 32'd12);

    // Frame 3: core never acknowledges; every pixel times out.
    step();
    core_stuck = 1'b1;
    push_frame(1'b1);
    pulse_start();
    n = 0;
    while (!core_enable && n < 20) begin step(); n++; end
    check("to_enable_seen", 32'(core_enable), 32'd1);
    n = 0;
    while (!fb_we && n < 60) begin step(); n++; end
    check("to_wait_cycles", 32'(n), 32'(TO));
    wait_frame_done(800);
    step(); step();
    check("to_err_set", 32'(timeout_err), 32'd1);
    core_stuck = 1'b0;

    // Frame 4: a fresh START clears the sticky error.
    salt = 9;
    push_frame(1'b0);
    pulse_start();
    check("to_err_cleared", 32'(timeout_err), 32'd0);
    wait_frame_done(400);
    step(); step();

    // Frames 5-7: continuous mode.
    salt = 1;
    push_frame(1'b0); push_frame(1'b0); push_frame(1'b0);
    fd0 = n_fd;
    continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      wait_frame_done(400);
      if (f == 2) begin
        continuous = 1'b0;
      end else begin
        step();
        check("cont_addr_zero", 32'(fb_addr), 32'd0);
        check("cont_enable_gap1", 32'(core_enable), 32'd0);
        step();
        check("cont_enable_gap2", 32'(core_enable), 32'd1);
      end
    end
    step(); step();
    check("cont_frames", 32'(n_fd - fd0), 32'd3);
    check("cont_count_literal", 32'(frame_count), 32'd7);
    check("cont_idle", 32'(busy), 32'd0);

    // Frame 8: START held high throughout gives exactly one frame.
    salt = 12;
    push_frame(1'b0);
    fd0 = n_fd;
    wr0 = n_wr;
    start = 1'b1;
    wait_frame_done(400);
    start = 1'b0;
    repeat (4) step();
    check("held_start_frames", 32'(n_fd - fd0), 32'd1);
    check("held_start_writes", 32'(n_wr - wr0), 32'd12);
    check("held_start_idle", 32'(busy), 32'd0);

    // Reset during WAIT_DONE of pixel 6.
    salt = 4;
    push_frame(1'b0);
    pulse_start();
    n = 0;
    while (!(core_enable && core_x == 10'd2 && core_y == 9'd1) && n < 200) begin step(); n++; end
    check("px6_enable_seen", 32'(core_enable && core_x == 10'd2 && core_y == 9'd1), 32'd1);
    step(); step();
    check("px6_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    repeat (8) step();
    salt = 11;
    push_frame(1'b0);
    chk_en = 1'b1;
    pulse_start();
    step();
    check("after_reset_xy", {13'd0, core_y, core_x}, 32'd0);
    wait_frame_done(400);
    check("after_reset_count", 32'(frame_count), 32'd1);
    step(); step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rt_pixel_scheduler.md
# rt_pixel_scheduler

Frame-level sequencer for the ray-tracing core. Walks the screen in raster order and hands one pixel coordinate at a time to `RTcore` over its ENABLE/OUTPUT_READY handshake. Collects each 4-bit result and writes it to the framebuffer with backpressure. Sits between the top-level frame control and `RTcore`/framebuffer, and is the only driver of `RTcore`'s ENABLE, X_in and Y_in.

## Interface
Parameters:
- H_RES, 640: pixels per line; X runs 0..H_RES-1.
- V_RES, 480: lines per frame; Y runs 0..V_RES-1.
- TIMEOUT, 4095: maximum cycles spent waiting on the core per pixel.
- ERR_PIXEL, 4'hC: value written for a pixel that timed out.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  begin a frame; sampled only in IDLE.
- CONTINUOUS  in  1  sampled in DONE; if high, start the next frame immediately.
- CORE_ENABLE  out  1  one-cycle request pulse to RTcore ENABLE.
- CORE_X  out  10  pixel X to RTcore X_in.
- CORE_Y  out  9  pixel Y to RTcore Y_in.
- CORE_READY  in  1  RTcore OUTPUT_READY; high when the core is idle or its result is valid.
- CORE_PIXEL  in  4  RTcore OUTPUT_PIXEL.
- FB_WE  out  1  framebuffer write request.
- FB_ADDR  out  19  linear address, Y*H_RES+X.
- FB_DATA  out  4  pixel value to write.
- FB_READY  in  1  framebuffer accepts the write in any cycle where FB_WE && FB_READY.
- BUSY  out  1  high in every state except IDLE.
- FRAME_DONE  out  1  one-cycle pulse at the end of each frame.
- FRAME_COUNT  out  16  completed frames; wraps from 16'hFFFF to 0.
- TIMEOUT_ERR  out  1  sticky flag; set on any core timeout, cleared when a frame starts from IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WRITE, DONE.
- IDLE: on START, clear X, Y, FB_ADDR and TIMEOUT_ERR, then go to ISSUE. START is ignored in every other state.
- ISSUE: assert CORE_ENABLE for exactly one cycle, then go to WAIT_ACK. CORE_X and CORE_Y hold stable from ISSUE until the pixel is written.
- WAIT_ACK: wait for CORE_READY==0, which means the core has accepted the request. The stale READY=1 from before the request must never be taken as a result. Go to WAIT_DONE.
- WAIT_DONE: on CORE_READY==1, latch CORE_PIXEL into FB_DATA and go to WRITE.
- Watchdog: one counter spans WAIT_ACK and WAIT_DONE and is cleared in ISSUE. If it reaches TIMEOUT, set FB_DATA=ERR_PIXEL, set TIMEOUT_ERR, and go to WRITE.
- WRITE: hold FB_WE high with FB_ADDR and FB_DATA stable until FB_READY. On the accepting edge:
  - if X==H_RES-1 and Y==V_RES-1, go to DONE;
  - else if X==H_RES-1, set X=0 and Y=Y+1;
  - else set X=X+1.
  - FB_ADDR increments by 1 on every accepted write. It is maintained incrementally; no multiplier.
  - Otherwise go to ISSUE.
- DONE: pulse FRAME_DONE and increment FRAME_COUNT.
  - If CONTINUOUS, clear X, Y and FB_ADDR and go to ISSUE. TIMEOUT_ERR is kept.
  - Else go to IDLE.
- Reset values: state IDLE; CORE_ENABLE, FB_WE, BUSY, FRAME_DONE and TIMEOUT_ERR at 0; CORE_X, CORE_Y, FB_ADDR, FB_DATA and FRAME_COUNT at 0.
- RESET mid-frame aborts immediately. No partial write is completed and CORE_ENABLE drops asynchronously. The core may still finish its pixel; the next START waits in WAIT_ACK as normal.
- All outputs are registered.

## Timing
- Per-pixel minimum is 1 (ISSUE) + WAIT_ACK cycles + WAIT_DONE cycles + 1 (WRITE with FB_READY already high).
- With RTcore's OUTPUT_READY dropping on the cycle after the ENABLE edge, WAIT_ACK lasts 1 cycle.
- START to first CORE_ENABLE: 2 rising edges (IDLE→ISSUE, then ENABLE registered high).
- Last accepted write to FRAME_DONE high: 1 cycle.
- In continuous mode, FRAME_DONE to the next CORE_ENABLE: 2 cycles.
- The exact-timeout boundary is defined: the timeout fires when the counter equals TIMEOUT, so the wait lasts TIMEOUT cycles.
- If CORE_READY rises on that same edge, the real pixel wins and TIMEOUT_ERR is not set.

## Structure
- Package `rt_pkg` holds:
  - H_RES and V_RES defaults;
  - `pixel_t` (logic [3:0]) and the coordinate typedefs `xcoord_t` [9:0] and `ycoord_t` [8:0];
  - the `sched_state_t` enum.
- One natural sub-module, `rt_raster_counter`. It owns X, Y, FB_ADDR and the last-pixel flag, with a clear input and an advance input.

## Test plan
Benches use H_RES=4, V_RES=3 and a behavioural core model with 5-cycle latency unless noted.
- Single frame with FB_READY held high:
  - START pulse → 12 writes at FB_ADDR 0..11;
  - CORE_X/CORE_Y sequence (0,0),(1,0)…(3,2);
  - FRAME_DONE once, FRAME_COUNT=1, then IDLE with BUSY=0.
- FB_READY low for 7 cycles during pixel 5 → FB_WE, FB_ADDR=5 and FB_DATA all held stable, with no extra CORE_ENABLE.
- Core model never drops READY with TIMEOUT=20 → each pixel is written as 4'hC and TIMEOUT_ERR=1. A later START from IDLE clears it.
- CONTINUOUS=1 for 3 frames → FRAME_COUNT 1,2,3, and FB_ADDR returns to 0 after each FRAME_DONE.
- START held high during a frame → exactly one frame, with no restart mid-frame.
- RESET asserted during WAIT_DONE of pixel 6 → all outputs at reset values immediately. A following START begins at (0,0), address 0.
